// File: rtl/alu_pkg.sv
// Shared opcode encodings, sequencer state type and command record for the
// accumulator ALU breadboard.
package alu_pkg;

  localparam int ALU_DW = 16;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_MULT  = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [ALU_DW-1:0] operand;
  } cmd_t;

  // Multi-cycle ALU operations that require the issue stage to wait.
  function automatic logic is_stall_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_NOR;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push_s;
  logic         do_pop_s;

  assign do_push_s = push && !full && !clr;
  assign do_pop_s  = pop && !empty && !clr;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign fill  = wr_q - rd_q;
  assign rdata = mem_q[rd_q[AW-1:0]];

  // Pointer next-state: clear wins over push/pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push_s) begin
        wr_d = wr_q + (AW+1)'(1);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = rd_q + (AW+1)'(1);
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the accumulator ALU: buffers commands and strobes at most one
// per cycle, stalling after MULT/DIV. Define ALU_SEQ_OPCODE_CHECK_EN to drop illegal opcodes.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DW        = ALU_DW,
  parameter int STALL_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   run,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_opcode,
  input  logic [DW-1:0]          cmd_operand,
  input  logic                   alu_busy,
  output logic                   alu_issue,
  output logic [3:0]             alu_opcode,
  output logic [DW-1:0]          alu_operand,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   illegal_op
);

  localparam int CW = $clog2(STALL_CYC + 1);

  seq_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            issue_q, issue_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [DW-1:0]   operand_q, operand_d;

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            slot_free_s;
  logic            legal_s;
  logic [DW+3:0]   head_s;
  logic [3:0]      head_op_s;
  logic [DW-1:0]   head_opnd_s;

  assign cmd_ready   = !full_s && !flush;
  assign push_s      = cmd_valid && cmd_ready;
  assign head_op_s   = head_s[DW+3:DW];
  assign head_opnd_s = head_s[DW-1:0];

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + 4)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({cmd_opcode, cmd_operand}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .fill  (fill)
  );

`ifdef ALU_SEQ_OPCODE_CHECK_EN
  logic illegal_q, illegal_d;

  assign legal_s    = is_legal_op(head_op_s);
  assign illegal_op = illegal_q;

  // Sticky illegal flag, cleared only by flush or reset.
  always_comb begin
    illegal_d = illegal_q;
    if (flush) begin
      illegal_d = 1'b0;
    end else if (pop_s && !legal_s) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Illegal flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`else
  assign legal_s    = 1'b1;
  assign illegal_op = 1'b0;
`endif

  // A stall ending this cycle frees the slot so the next pop is not delayed.
  assign slot_free_s = (state_q == IDLE) || ((cnt_q == '0) && !alu_busy);

  // FSM next-state, pop decision and output staging.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_s     = 1'b0;
    issue_d   = 1'b0;
    opcode_d  = OP_NOOP;
    operand_d = '0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      pop_s = run && !empty_s && slot_free_s;
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        STALL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (!alu_busy) begin
            state_d = IDLE;
          end else begin
            state_d = STALL;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (pop_s) begin
        issue_d = legal_s;
        if (legal_s && is_stall_op(head_op_s)) begin
          state_d = STALL;
          cnt_d   = CW'(STALL_CYC);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end else begin
        issue_d = 1'b0;
      end
      if (issue_d) begin
        opcode_d  = head_op_s;
        operand_d = head_opnd_s;
      end else begin
        opcode_d  = OP_NOOP;
        operand_d = '0;
      end
    end
  end

  // State, stall counter and registered ALU command outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      issue_q   <= 1'b0;
      opcode_q  <= OP_NOOP;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      issue_q   <= issue_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  assign alu_issue   = issue_q;
  assign alu_opcode  = opcode_q;
  assign alu_operand = operand_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed, table-driven bench for alu_cmd_sequencer (DEPTH=4, DW=16, STALL_CYC=2);
// expectations follow ALU_SEQ_OPCODE_CHECK_EN when it is defined.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic        run;
    logic        valid;
    logic        flush;
    logic        busy;
    logic [3:0]  op;
    logic [15:0] opnd;
    logic        e_ready;
    logic        e_issue;
    logic [3:0]  e_op;
    logic [15:0] e_opnd;
    logic [2:0]  e_fill;
    logic        e_ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        run;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_operand;
  logic        alu_busy;
  logic        alu_issue;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_operand;
  logic [2:0]  fill;
  logic        illegal_op;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DEPTH     (4),
    .DW        (16),
    .STALL_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .run         (run),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_operand (cmd_operand),
    .alu_busy    (alu_busy),
    .alu_issue   (alu_issue),
    .alu_opcode  (alu_opcode),
    .alu_operand (alu_operand),
    .fill        (fill),
    .illegal_op  (illegal_op)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic run_i, input logic valid_i, input logic flush_i,
                         input logic busy_i, input logic [3:0] op_i, input logic [15:0] opnd_i,
                         input logic e_ready_i, input logic e_issue_i, input logic [3:0] e_op_i,
                         input logic [15:0] e_opnd_i, input logic [2:0] e_fill_i,
                         input logic e_ill_i);
    vec_t v;
    v.run = run_i;       v.valid = valid_i;     v.flush = flush_i;   v.busy = busy_i;
    v.op = op_i;         v.opnd = opnd_i;       v.e_ready = e_ready_i;
    v.e_issue = e_issue_i; v.e_op = e_op_i;     v.e_opnd = e_opnd_i;
    v.e_fill = e_fill_i; v.e_ill = e_ill_i;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    run = 1'b0; cmd_valid = 1'b0; flush = 1'b0; alu_busy = 1'b0;
    cmd_opcode = 4'h0; cmd_operand = 16'h0000;
  endtask

  task automatic check_outputs(input string tag, input logic e_issue, input logic [3:0] e_op,
                               input logic [15:0] e_opnd, input logic [2:0] e_fill,
                               input logic e_ill);
    check({tag, ".issue"},   32'(alu_issue),   32'(e_issue));
    check({tag, ".opcode"},  32'(alu_opcode),  32'(e_op));
    check({tag, ".operand"}, 32'(alu_operand), 32'(e_opnd));
    check({tag, ".fill"},    32'(fill),        32'(e_fill));
    check({tag, ".illegal"}, 32'(illegal_op),  32'(e_ill));
  endtask

  initial begin
    // run valid flush busy op opnd | ready issue op opnd fill ill
    // Streaming: three back-to-back ALU ops.
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_ADD,  16'h0005, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_SUB,  16'h0003, 1'b1, 1'b1, OP_ADD,  16'h0005, 3'd1, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_AND,  16'hF0F0, 1'b1, 1'b1, OP_SUB,  16'h0003, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_AND,  16'hF0F0, 3'd0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    // Full: fifth command held until space frees, then drained in order.
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_XOR,  16'h0001, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_OR,   16'h0002, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd2, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD,  16'h0003, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd3, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_SUB,  16'h0004, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd4, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_NOR,  16'h0005, 1'b0, 1'b0, OP_NOOP, 16'h0000, 3'd4, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_NOR,  16'h0005, 1'b0, 1'b1, OP_XOR,  16'h0001, 3'd3, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_NOR,  16'h0005, 1'b1, 1'b1, OP_OR,   16'h0002, 3'd3, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_ADD,  16'h0003, 3'd2, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_SUB,  16'h0004, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_NOR,  16'h0005, 3'd0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    // Stall: MULT then ADD with alu_busy high for four cycles after the MULT strobe.
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_MULT, 16'h0007, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_ADD,  16'h0001, 1'b1, 1'b1, OP_MULT, 16'h0007, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_ADD,  16'h0001, 3'd0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    // Stall: DIV with ALU idle waits exactly the minimum two cycles.
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_DIV,  16'h0002, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_OR,   16'h0003, 1'b1, 1'b1, OP_DIV,  16'h0002, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_OR,   16'h0003, 3'd0, 1'b0);
    // run drops during a stall: stall finishes, nothing pops until run returns.
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_MULT, 16'h0004, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_XOR,  16'h0006, 1'b1, 1'b1, OP_MULT, 16'h0004, 3'd1, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_XOR,  16'h0006, 3'd0, 1'b0);
    // Flush: queued commands and the simultaneous push are discarded.
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD,  16'h0001, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_SUB,  16'h0002, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd2, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, OP_AND,  16'h0003, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd3, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, OP_XOR,  16'h0009, 1'b0, 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    // Illegal opcode 1100 followed by OR; flush clears the sticky flag.
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, 4'hC,    16'h0000, 1'b1, 1'b0, OP_NOOP, 16'h0000, 3'd1, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, OP_OR,   16'h0001, 1'b1, CHK_EN ? 1'b0 : 1'b1,
            CHK_EN ? OP_NOOP : 4'hC, 16'h0000, 3'd1, CHK_EN);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, OP_NOOP, 16'h0000, 1'b1, 1'b1, OP_OR,   16'h0001, 3'd0, CHK_EN);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, OP_NOOP, 16'h0000, 1'b0, 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);

    idle_inputs();
    rst = 1'b0;
    #12;
    check_outputs("reset", 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    check("reset.ready", 32'(cmd_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs("release", 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    check("release.ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run = vecs[i].run;     cmd_valid = vecs[i].valid;  flush = vecs[i].flush;
      alu_busy = vecs[i].busy; cmd_opcode = vecs[i].op;  cmd_operand = vecs[i].opnd;
      #1;
      check($sformatf("v%0d.ready", i), 32'(cmd_ready), 32'(vecs[i].e_ready));
      @(posedge clk); #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_issue, vecs[i].e_op, vecs[i].e_opnd,
                    vecs[i].e_fill, vecs[i].e_ill);
    end

    // Mid-cycle asynchronous reset with a strobe on the outputs and one entry queued.
    idle_inputs();
    cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_operand = 16'h0002;
    @(posedge clk); #1;
    cmd_opcode = OP_SUB; cmd_operand = 16'h0003;
    @(posedge clk); #1;
    cmd_valid = 1'b0; run = 1'b1;
    @(posedge clk); #1;
    check_outputs("pre_rst", 1'b1, OP_ADD, 16'h0002, 3'd1, 1'b0);
    run = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    check("async_rst.ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    run = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_rst", 1'b0, OP_NOOP, 16'h0000, 3'd0, 1'b0);
    check("post_rst.ready", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
